// File: rtl/uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_pkg
// Description : Shared types and constants for the 8N1/8P1 UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_tx_pkg;

    localparam int   DATA_W    = 8;
    localparam int   CNT_W     = $clog2(DATA_W);

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/uart_tx_fsm.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fsm
// Description : Frame sequencer: state register, data bit counter and busy.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fsm
    import uart_tx_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_data_valid,
    input  logic             i_par_en,
    output state_t           o_state,
    output logic [CNT_W-1:0] o_bit_cnt,
    output logic             o_busy,
    output logic             o_accept
);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_bit_cnt;
    logic             r_busy;
    logic             w_accept;

    // A word is taken when idle, or while the stop bit is being launched so
    // that the next start bit follows without a gap.
    assign w_accept = i_data_valid && ((r_state == IDLE) || (r_state == STOP));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = START;
            START:   w_state_next = DATA;
            DATA:    if (r_bit_cnt == CNT_W'(DATA_W - 1))
                         w_state_next = i_par_en ? PARITY : STOP;
            PARITY:  w_state_next = STOP;
            STOP:    w_state_next = w_accept ? START : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // The line driver in the top registers the bit for the current state, so
    // busy is delayed by one cycle to stay aligned with the line.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_busy    <= (r_state != IDLE);
            r_bit_cnt <= (r_state == DATA) ? r_bit_cnt + 1'b1 : '0;
        end
    end

    assign o_state   = r_state;
    assign o_bit_cnt = r_bit_cnt;
    assign o_busy    = r_busy;
    assign o_accept  = w_accept;

endmodule
`default_nettype wire

// File: rtl/uart_tx_top.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_top
// Description : UART transmitter, one bit per clk, optional even/odd parity.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_top
    import uart_tx_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] P_DATA,
    input  logic              Data_Valid,
    input  logic              PAR_EN,
    input  logic              PAR_TYP,
    output logic              TX_OUT_top,
    output logic              busy_top
);

    state_t           w_state;
    logic [CNT_W-1:0] w_bit_cnt;
    logic             w_busy;
    logic             w_accept;

    logic [DATA_W-1:0] r_data;
    logic              r_par_en;
    logic              r_par_typ;
    logic              r_tx;
    logic              w_parity;

    uart_tx_fsm u_fsm (
        .clk          (clk),
        .rst          (rst),
        .i_data_valid (Data_Valid),
        .i_par_en     (r_par_en),
        .o_state      (w_state),
        .o_bit_cnt    (w_bit_cnt),
        .o_busy       (w_busy),
        .o_accept     (w_accept)
    );

    // The frame in flight only ever sees these copies.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data    <= '0;
            r_par_en  <= 1'b0;
            r_par_typ <= PAR_EVEN;
        end else if (w_accept) begin
            r_data    <= P_DATA;
            r_par_en  <= PAR_EN;
            r_par_typ <= PAR_TYP;
        end
    end

    assign w_parity = (^r_data) ^ (r_par_typ == PAR_ODD);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx <= STOP_BIT;
        end else begin
            case (w_state)
                START:   r_tx <= START_BIT;
                DATA:    r_tx <= r_data[w_bit_cnt];
                PARITY:  r_tx <= w_parity;
                default: r_tx <= STOP_BIT;
            endcase
        end
    end

    assign TX_OUT_top = r_tx;
    assign busy_top   = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_top.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_top
// Description : Directed self-checking bench for uart_tx_top.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_top;

    logic       clk;
    logic       rst;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       TX_OUT_top;
    logic       busy_top;

    int n_checks;
    int n_errors;

    uart_tx_top dut (
        .clk        (clk),
        .rst        (rst),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .TX_OUT_top (TX_OUT_top),
        .busy_top   (busy_top)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Inputs change on falling edges; the next rising edge is acceptance edge A.
    // Returns in the A..A+1 gap after scrambling the inputs.
    task automatic start_frame(input logic [7:0] d, input logic pe, input logic pt,
                               input string tag);
        @(negedge clk);
        P_DATA = d; PAR_EN = pe; PAR_TYP = pt; Data_Valid = 1'b1;
        @(negedge clk);
        Data_Valid = 1'b0;
        P_DATA = ~d; PAR_EN = ~pe; PAR_TYP = ~pt;
        chk({tag, "_gap_tx"}, {7'd0, TX_OUT_top}, 8'd1);
        chk({tag, "_gap_busy"}, {7'd0, busy_top}, 8'd0);
    endtask

    // Checks n line bits (time order MSB first in bits[n-1:0]); optionally
    // raises Data_Valid for edge A+poke_k.
    task automatic watch(input logic [10:0] bits, input int n, input int poke_k,
                         input logic [7:0] poke_d, input string tag);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            Data_Valid = 1'b0;
            chk($sformatf("%s_bit%0d", tag, k), {7'd0, TX_OUT_top}, {7'd0, bits[n-k]});
            chk($sformatf("%s_busy%0d", tag, k), {7'd0, busy_top}, 8'd1);
            if (k == poke_k - 1) begin
                P_DATA = poke_d; PAR_EN = 1'b1; PAR_TYP = 1'b0; Data_Valid = 1'b1;
            end
        end
    endtask

    task automatic expect_idle(input int cycles, input string tag);
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            Data_Valid = 1'b0;
            chk($sformatf("%s_idle_tx%0d", tag, k), {7'd0, TX_OUT_top}, 8'd1);
            chk($sformatf("%s_idle_busy%0d", tag, k), {7'd0, busy_top}, 8'd0);
        end
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        rst = 1'b1; P_DATA = 8'h00; Data_Valid = 1'b0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx", {7'd0, TX_OUT_top}, 8'd1);
        chk("rst_busy", {7'd0, busy_top}, 8'd0);
        rst = 1'b0;
        expect_idle(2, "post_rst");

        // Odd parity: 0, 1,0,1,1,0,0,1,1, 0, 1
        start_frame(8'b11001101, 1'b1, 1'b1, "odd");
        watch(11'b0_10110011_0_1, 11, 0, 8'h00, "odd");
        expect_idle(2, "odd");

        // Even parity: 0, 1,0,0,1,0,0,1,1, 0, 1
        start_frame(8'b11001001, 1'b1, 1'b0, "even");
        watch(11'b0_10010011_0_1, 11, 0, 8'h00, "even");
        expect_idle(2, "even");

        // No parity: 0, 1,0,1,1,0,0,1,1, 1 ; busy falls at A+11
        start_frame(8'b11001101, 1'b0, 1'b0, "nopar");
        watch(11'b0_10110011_1, 10, 0, 8'h00, "nopar");
        expect_idle(2, "nopar");

        // Mid-frame Data_Valid at A+6 is ignored
        start_frame(8'b11001001, 1'b1, 1'b0, "iso");
        watch(11'b0_10010011_0_1, 11, 6, 8'b11011001, "iso");
        expect_idle(4, "iso");

        // Back-to-back: second word accepted on edge A+11
        start_frame(8'b11001001, 1'b1, 1'b0, "b2b1");
        watch(11'b0_10010011_0_1, 11, 11, 8'b11001101, "b2b1");
        // second word 11001101 even parity: ones=5 -> parity 1
        watch(11'b0_10110011_1_1, 11, 0, 8'h00, "b2b2");
        expect_idle(2, "b2b");

        // Reset mid-data aborts the frame
        start_frame(8'b11001101, 1'b1, 1'b1, "abort");
        repeat (4) @(negedge clk);
        chk("abort_busy_before", {7'd0, busy_top}, 8'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_tx", {7'd0, TX_OUT_top}, 8'd1);
        chk("abort_busy", {7'd0, busy_top}, 8'd0);
        rst = 1'b0;
        expect_idle(2, "abort");
        start_frame(8'b11001101, 1'b1, 1'b1, "after_rst");
        watch(11'b0_10110011_0_1, 11, 0, 8'h00, "after_rst");
        expect_idle(2, "after_rst");

        // Reset wins over a simultaneous Data_Valid
        @(negedge clk);
        rst = 1'b1; Data_Valid = 1'b1; P_DATA = 8'hA5;
        @(negedge clk);
        rst = 1'b0; Data_Valid = 1'b0;
        expect_idle(3, "rst_dv");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_top.md
# uart_tx_top

Parameter-free UART transmitter. It accepts one 8-bit word per Data_Valid pulse and serializes it on TX_OUT_top as a start bit, 8 data bits LSB first, an optional parity bit and one stop bit, at one bit per clk cycle. Baud-rate division is the responsibility of the clock source upstream. It sits between a parallel data producer and the serial line, and reports frame activity on busy_top.

## Interface
- No parameters. Data width is fixed at 8; frame length is 11 cycles with parity, 10 without.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- P_DATA  in  8  parallel word, sampled on the acceptance edge.
- Data_Valid  in  1  request strobe; a 1-cycle pulse is sufficient.
- PAR_EN  in  1  1 = insert parity bit; sampled on the acceptance edge.
- PAR_TYP  in  1  0 = even, 1 = odd; sampled on the acceptance edge.
- TX_OUT_top  out  1  serial line, registered; idles high.
- busy_top  out  1  high while a frame is on the line, registered.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- State transitions:
  - IDLE -> START on Data_Valid.
  - START -> DATA.
  - DATA -> PARITY after 8 bits if PAR_EN was latched as 1, otherwise DATA -> STOP.
  - PARITY -> STOP.
  - STOP -> START if a new word was accepted, otherwise STOP -> IDLE.
- Acceptance edge A: a rising edge where Data_Valid=1 and either:
  - the block is idle, or
  - edge A is the edge on which the stop bit begins (back-to-back continuation).
- On acceptance, P_DATA, PAR_EN and PAR_TYP are copied into internal registers. The frame uses only these latched copies.
- Data_Valid at any other edge while busy is ignored. Input changes after acceptance do not affect the frame in flight.
- Parity is computed from the latched data:
  - even: bit = XOR of the 8 data bits.
  - odd: bit = inverted XOR of the 8 data bits.
- Line levels: start bit = 0, stop bit = 1, idle = 1.

## Timing
- Reset (rst=1 at an edge): state IDLE, TX_OUT_top=1, busy_top=0, latched registers cleared. Reset mid-frame aborts the frame on that edge.
- Latency: one idle cycle (A..A+1) after acceptance; the line stays high during it.
- Frame with parity, as line cycles between edges:
  - start bit: A+1..A+2
  - data[i]: A+2+i..A+3+i, for i=0..7
  - parity: A+10..A+11
  - stop: A+11..A+12
- Frame without parity: stop bit occupies A+10..A+11; there is no parity slot.
- busy_top: 1 from edge A+1 through the end of the stop bit; 0 again at A+12 (with parity) or A+11 (without), unless a continuation was accepted.
- Back-to-back: if Data_Valid=1 on the edge where the stop bit begins, that edge is the new A'. Its start bit follows the stop bit with no gap and busy_top stays high.
- Data_Valid held high continuously produces back-to-back frames.
- Simultaneous rst=1 and Data_Valid=1: reset wins.

## Structure
- Shared package uart_tx_pkg holds:
  - the state enum,
  - DATA_W = 8,
  - START_BIT = 0, STOP_BIT = 1,
  - PAR_EVEN = 0, PAR_ODD = 1.
- Natural sub-module: uart_tx_fsm (state register, bit counter, busy).
- The top level holds the latched data register, the parity XOR and the registered output mux.

## Test plan
- Odd parity: PAR_EN=1, PAR_TYP=1, P_DATA=8'b11001101, 1-cycle Data_Valid. Line from A+1, in time order: 0, 1,0,1,1,0,0,1,1, 0, 1. busy_top high throughout.
- Even parity: P_DATA=8'b11001001, PAR_TYP=0. Line: 0, 1,0,0,1,0,0,1,1, 0, 1.
- No parity: PAR_EN=0, P_DATA=8'b11001101. Line: 0, 1,0,1,1,0,0,1,1, 1. busy_top falls at A+11.
- Input isolation: even parity, P_DATA=8'b11001001 accepted. At A+6 pulse Data_Valid with P_DATA=8'b11011001. Remaining bits are unchanged, parity bit = 0, no extra frame.
- Back-to-back: even parity, second Data_Valid pulse on edge A+11. Second start bit at A+12..A+13, busy_top never drops between frames.
- Reset: assert rst mid-data. Next edge gives TX_OUT_top=1, busy_top=0, and a new Data_Valid is accepted normally afterwards.
